// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller of the asynchronous FIFO.
//
// Brings the gray write pointer into the read clock domain through a two-flop
// synchronizer and decodes it to binary. Owns the read pointer (binary and
// gray), drives the RAM read port, and reports empty, occupancy, read-valid
// and underflow status. All state updates happen on the falling edge of clk.
//
// Ports:
//   clk          read-domain clock (falling-edge active)
//   clear        synchronous active-high reset of the read side
//   wr_ptr_gray  gray write pointer from the write domain (asynchronous)
//   rd_req       read request from the consumer
//   mem_rd_en    RAM read enable (combinational)
//   rd_addr      RAM read address
//   rd_valid     RAM output data valid (one cycle after mem_rd_en)
//   rd_ptr_gray  registered gray read pointer, returned to the write domain
//   empty        FIFO empty (registered)
//   rd_count     occupancy as seen from the read domain (registered)
//   underflow    one-cycle pulse when rd_req arrives while empty

module fifo_read_ctrl #(
    parameter int unsigned ADDRWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [ADDRWIDTH:0]   wr_ptr_gray,
    input  logic                 rd_req,
    output logic                 mem_rd_en,
    output logic [ADDRWIDTH-1:0] rd_addr,
    output logic                 rd_valid,
    output logic [ADDRWIDTH:0]   rd_ptr_gray,
    output logic                 empty,
    output logic [ADDRWIDTH:0]   rd_count,
    output logic                 underflow
);

    localparam int unsigned PW = ADDRWIDTH + 1;

    logic [PW-1:0] wq1;
    logic [PW-1:0] wq2;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic          accept;

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wbin[i] = ^(wq2 >> i);
        end
    end

    always_comb begin
        accept      = rd_req & ~empty;
        rd_bin_next = rd_bin + PW'(accept);
        mem_rd_en   = rd_req & ~empty & ~clear;
        rd_addr     = rd_bin[ADDRWIDTH-1:0];
    end

    // empty and rd_count compare against the pre-edge wbin; a write pointer
    // arriving in wq2 on this edge shows up in the status one edge later.
    always_ff @(negedge clk) begin
        if (clear) begin
            wq1         <= '0;
            wq2         <= '0;
            rd_bin      <= '0;
            rd_ptr_gray <= '0;
            empty       <= 1'b1;
            rd_count    <= '0;
            rd_valid    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            wq1         <= wr_ptr_gray;
            wq2         <= wq1;
            rd_bin      <= rd_bin_next;
            rd_ptr_gray <= rd_bin_next ^ (rd_bin_next >> 1);
            empty       <= (rd_bin_next == wbin);
            rd_count    <= wbin - rd_bin_next;
            rd_valid    <= accept;
            underflow   <= rd_req & empty;
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

    localparam int AW   = 4;
    localparam int PW   = AW + 1;
    localparam int MASK = (1 << PW) - 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic [PW-1:0] wr_ptr_gray = '0;
    logic          rd_req = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [PW-1:0] rd_ptr_gray;
    logic          empty;
    logic [PW-1:0] rd_count;
    logic          underflow;

    fifo_read_ctrl #(.ADDRWIDTH(AW)) dut (
        .clk        (clk),
        .clear      (clear),
        .wr_ptr_gray(wr_ptr_gray),
        .rd_req     (rd_req),
        .mem_rd_en  (mem_rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_ptr_gray(rd_ptr_gray),
        .empty      (empty),
        .rd_count   (rd_count),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: write counts seen through a two-stage delay line, read
    // count as a plain integer, everything else derived arithmetically.
    int m_p1 = 0, m_p2 = 0;   // write count one and two samples back
    int m_rd = 0;             // read count
    int m_count = 0;          // registered occupancy
    int m_valid = 0, m_uf = 0;
    int wr = 0;               // write count driven by the bench
    logic [PW-1:0] prev_gray = '0;

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b & MASK);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge: drive inputs, check combinational
    // outputs, let the falling edge happen, advance the model, check state.
    task automatic cycle(input logic req, input logic clr, input int wr_val);
        int acc;
        rd_req      = req;
        clear       = clr;
        wr          = wr_val & MASK;
        wr_ptr_gray = to_gray(wr);
        #1;
        chk("mem_rd_en", 32'(mem_rd_en), 32'(req && !clr && m_count != 0));
        if (!clr) chk("rd_addr", 32'(rd_addr), 32'(m_rd % DEPTH));
        @(negedge clk);
        if (clr) begin
            m_p1 = 0; m_p2 = 0; m_rd = 0; m_count = 0; m_valid = 0; m_uf = 0;
        end else begin
            acc     = (req && m_count != 0) ? 1 : 0;
            m_uf    = (req && m_count == 0) ? 1 : 0;
            m_valid = acc;
            m_rd    = (m_rd + acc) & MASK;
            m_count = (m_p2 - m_rd) & MASK;
            m_p2    = m_p1;
            m_p1    = wr;
        end
        @(posedge clk);
        #1;
        chk("rd_count", 32'(rd_count), 32'(m_count));
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("rd_ptr_gray", 32'(rd_ptr_gray), 32'(to_gray(m_rd)));
        if (!clr) chk("gray_one_bit", 32'($countones(rd_ptr_gray ^ prev_gray) <= 1), 32'd1);
        prev_gray = rd_ptr_gray;
    endtask

    initial begin
        int guard;
        @(posedge clk);
        #1;

        // Reset
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_gray", 32'(rd_ptr_gray), 32'd0);

        // Sync latency: three entries appear two edges after the pointer moves
        cycle(1'b0, 1'b0, 3);
        chk("lat_k_count", 32'(rd_count), 32'd0);
        cycle(1'b0, 1'b0, 3);
        chk("lat_k1_count", 32'(rd_count), 32'd0);
        cycle(1'b0, 1'b0, 3);
        chk("lat_k2_count", 32'(rd_count), 32'd3);
        chk("lat_k2_empty", 32'(empty), 32'd0);

        // Drain three entries, then underflow on the fourth request
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 3);
        chk("drain_gray", 32'(rd_ptr_gray), 32'b00010);
        chk("drain_underflow", 32'(underflow), 32'd1);
        cycle(1'b0, 1'b0, 3);

        // Clear while reading with five entries available
        cycle(1'b0, 1'b0, 8);
        cycle(1'b0, 1'b0, 8);
        cycle(1'b1, 1'b0, 8);
        cycle(1'b1, 1'b1, 0);
        chk("clear_count", 32'(rd_count), 32'd0);
        chk("clear_valid", 32'(rd_valid), 32'd0);
        prev_gray = '0;

        // Walk the read pointer up to 30, then wrap through 0
        for (int w = 1; w <= 30; w++) cycle(1'b1, 1'b0, w);
        guard = 0;
        while (m_rd != 30 && guard < 20) begin
            cycle(1'b1, 1'b0, 30);
            guard++;
        end
        chk("wrap_reach", 32'(m_rd), 32'd30);
        cycle(1'b0, 1'b0, 33);
        cycle(1'b0, 1'b0, 33);
        cycle(1'b0, 1'b0, 33);
        chk("wrap_count", 32'(rd_count), 32'd3);
        chk("wrap_gray0", 32'(rd_ptr_gray), 32'b10001);
        cycle(1'b1, 1'b0, 33);
        chk("wrap_gray1", 32'(rd_ptr_gray), 32'b10000);
        cycle(1'b1, 1'b0, 33);
        chk("wrap_gray2", 32'(rd_ptr_gray), 32'b00000);
        cycle(1'b1, 1'b0, 33);
        chk("wrap_gray3", 32'(rd_ptr_gray), 32'b00001);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Read the single entry while the write pointer keeps advancing
        cycle(1'b0, 1'b0, 2);
        cycle(1'b0, 1'b0, 3);
        cycle(1'b1, 1'b0, 4);
        cycle(1'b1, 1'b0, 4);
        cycle(1'b1, 1'b0, 4);
        cycle(1'b0, 1'b0, 4);

        // Randomized traffic with a well-behaved write side
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                cycle(1'($urandom_range(0, 1)), 1'b1, 0);
                prev_gray = '0;
            end else begin
                int nw;
                nw = wr;
                if ((((wr - m_rd) & MASK) < DEPTH) && $urandom_range(0, 2) != 0) nw = wr + 1;
                cycle(1'($urandom_range(0, 1)), 1'b0, nw);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
